// File: rtl/timer_ctrl_if.sv
// Bus bundle for timer_ctrl: register access strobes, read data and the
// two status outputs (interrupt level and prescaler tick).
interface timer_ctrl_if;
  logic        en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;
  logic        tick;

  modport master (
    output en, wr_en, addr, data_in,
    input  data_out, irq, tick
  );

  modport slave (
    input  en, wr_en, addr, data_in,
    output data_out, irq, tick
  );
endinterface

// File: rtl/timer_ctrl.sv
// Four-channel down-counting timer sharing one free-running prescaler tick,
// with auto-reload, per-channel pending flags and a level interrupt.
module timer_ctrl #(
  parameter int CLOCK_FREQUENCY  = 50_000_000,
  parameter int TICKS_PER_SECOND = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);

  localparam int          PCOUNT   = CLOCK_FREQUENCY / TICKS_PER_SECOND - 1;
  localparam logic [23:0] PCOUNT_W = 24'(PCOUNT);

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [23:0] r_presc;
  logic [15:0] r_count  [4];
  logic [15:0] r_reload [4];
  logic [3:0]  r_run;
  logic [3:0]  r_auto;
  logic [3:0]  r_irqen;
  logic [3:0]  r_pend;
  logic [15:0] r_dout;

  logic        w_tick;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_ch;
  logic [1:0]  w_reg;
  logic [15:0] w_rdata;
  logic [3:0]  w_dec;
  logic [3:0]  w_expire;

  // Value a channel lands on when it expires: RELOAD in auto mode, else stop at 0.
  function automatic logic [15:0] f_expire_value(input logic autom,
                                                 input logic [15:0] reload);
    return autom ? reload : 16'd0;
  endfunction

  assign w_tick = (r_presc == PCOUNT_W);
  assign w_wr   = bus.en & bus.wr_en;
  assign w_rd   = bus.en & ~bus.wr_en;
  assign w_ch   = bus.addr[3:2];
  assign w_reg  = bus.addr[1:0];

  // A channel only moves on a tick while running with a nonzero count.
  always_comb begin
    w_dec    = '0;
    w_expire = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_tick && r_run[i] && (r_count[i] != 16'd0)) begin
        w_dec[i]    = (r_count[i] != 16'd1);
        w_expire[i] = (r_count[i] == 16'd1);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_COUNT:  w_rdata = r_count[w_ch];
      REG_RELOAD: w_rdata = r_reload[w_ch];
      REG_CTRL:   w_rdata = {13'd0, r_irqen[w_ch], r_auto[w_ch], r_run[w_ch]};
      REG_STATUS: w_rdata = {8'd0, r_pend, 3'd0, r_pend[w_ch]};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_run   <= '0;
      r_auto  <= '0;
      r_irqen <= '0;
      r_pend  <= '0;
      r_dout  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_count[i]  <= '0;
        r_reload[i] <= '0;
      end
    end else begin
      r_presc <= w_tick ? 24'd0 : r_presc + 24'd1;

      if (w_rd) begin
        r_dout <= w_rdata;
      end

      for (int i = 0; i < 4; i++) begin
        // A host COUNT write overrides whatever the tick would have done.
        if (w_wr && (w_ch == 2'(i)) && (w_reg == REG_COUNT)) begin
          r_count[i] <= bus.data_in;
        end else if (w_dec[i]) begin
          r_count[i] <= r_count[i] - 16'd1;
        end else if (w_expire[i]) begin
          r_count[i] <= f_expire_value(r_auto[i], r_reload[i]);
        end

        if (w_wr && (w_ch == 2'(i)) && (w_reg == REG_RELOAD)) begin
          r_reload[i] <= bus.data_in;
        end

        if (w_wr && (w_ch == 2'(i)) && (w_reg == REG_CTRL)) begin
          r_run[i]   <= bus.data_in[0];
          r_auto[i]  <= bus.data_in[1];
          r_irqen[i] <= bus.data_in[2];
        end

        // Expiry wins over a simultaneous clear so no event is lost.
        if (w_expire[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_wr && (w_ch == 2'(i)) && (w_reg == REG_STATUS) && bus.data_in[0]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.data_out = r_dout;
  assign bus.tick     = w_tick;
  assign bus.irq      = |(r_pend & r_irqen);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (PCOUNT=9): register reads are scored through
// an expected-value queue drained by a monitor when read data becomes valid.
module tb_timer_ctrl;

  logic clk;
  logic rst_n;
  logic rd_issued;

  timer_ctrl_if bus ();

  timer_ctrl #(
    .CLOCK_FREQUENCY (10),
    .TICKS_PER_SECOND(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is valid the cycle after a read strobe is sampled.
  always @(posedge clk) rd_issued <= bus.en & ~bus.wr_en & rst_n;

  always @(negedge clk) begin
    if (rd_issued === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: data_out=%h with no expected entry", bus.data_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.data_out !== e.exp) begin
          errors++;
          $display("FAIL %s: data_out=%h expected %h", e.name, bus.data_out, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.en = 1'b1; bus.wr_en = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.en = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string name);
    exp_t e;
    e.exp = exp; e.name = name;
    sbq.push_back(e);
    bus.en = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 25) begin
      @(negedge clk);
      n++;
    end
    if (bus.tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: tick=%b after %0d cycles expected 1", bus.tick, n);
    end
  endtask

  // Returns one cycle after the tick edge, so channel updates are visible.
  task automatic tick_pass();
    wait_tick();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tick", {15'd0, bus.tick}, 16'd0);
    chk("rst_irq", {15'd0, bus.irq}, 16'd0);
    chk("rst_dout", bus.data_out, 16'd0);

    // Idle after reset: ticks at cycles 9, 19, 29.
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      chk($sformatf("idle_tick_c%0d", c), {15'd0, bus.tick}, {15'd0, (c % 10 == 9)});
      @(negedge clk);
    end
    chk("idle_dout", bus.data_out, 16'd0);
    chk("idle_irq", {15'd0, bus.irq}, 16'd0);

    // One-shot countdown on ch0 with interrupt.
    tick_pass();
    wr(4'h0, 16'd3);
    wr(4'h2, 16'h5);
    tick_pass(); rd(4'h0, 16'd2, "ch0_cnt2");
    tick_pass(); rd(4'h0, 16'd1, "ch0_cnt1");
    tick_pass(); rd(4'h0, 16'd0, "ch0_cnt0");
    rd(4'h3, 16'h0011, "ch0_status");
    chk("ch0_irq_set", {15'd0, bus.irq}, 16'd1);
    wr(4'h3, 16'h1);
    chk("ch0_irq_clr", {15'd0, bus.irq}, 16'd0);

    // Auto-reload on ch1 without interrupt enable.
    tick_pass();
    wr(4'h4, 16'd2);
    wr(4'h5, 16'd4);
    wr(4'h6, 16'h3);
    tick_pass(); tick_pass();
    rd(4'h4, 16'd4, "ch1_reload1");
    rd(4'h7, 16'h0021, "ch1_status1");
    chk("ch1_irq1", {15'd0, bus.irq}, 16'd0);
    repeat (4) tick_pass();
    rd(4'h4, 16'd4, "ch1_reload2");
    rd(4'h7, 16'h0021, "ch1_status2");
    chk("ch1_irq2", {15'd0, bus.irq}, 16'd0);
    wr(4'h6, 16'h0);
    wr(4'h7, 16'h1);

    // COUNT write colliding with a tick on running ch2.
    tick_pass();
    wr(4'h8, 16'h0020);
    wr(4'hA, 16'h1);
    wait_tick();
    wr(4'h8, 16'h0010);
    rd(4'h8, 16'h0010, "ch2_write_vs_tick");

    // STATUS clear colliding with ch3 expiry.
    tick_pass();
    wr(4'hC, 16'd1);
    wr(4'hE, 16'h5);
    wait_tick();
    wr(4'hF, 16'h1);
    rd(4'hF, 16'h0081, "ch3_set_vs_clear");
    chk("ch3_irq_set", {15'd0, bus.irq}, 16'd1);
    wr(4'hF, 16'h1);
    chk("ch3_irq_clr", {15'd0, bus.irq}, 16'd0);

    // Stopped channel holds; running channel at zero neither wraps nor expires.
    tick_pass();
    wr(4'h2, 16'h0);
    wr(4'h0, 16'd5);
    repeat (3) tick_pass();
    rd(4'h0, 16'd5, "ch0_stopped_hold");
    wr(4'h0, 16'd0);
    wr(4'h2, 16'h1);
    repeat (2) tick_pass();
    rd(4'h0, 16'd0, "ch0_zero_hold");
    rd(4'h3, 16'h0000, "no_pending");

    // Reset in the middle of activity on ch2.
    tick_pass();
    wr(4'h8, 16'd1);
    wr(4'hA, 16'h5);
    tick_pass();
    wr(4'h8, 16'd7);
    chk("ch2_irq_before_rst", {15'd0, bus.irq}, 16'd1);
    rd(4'hB, 16'h0041, "ch2_status_before_rst");
    rd(4'h8, 16'd7, "ch2_cnt_before_rst");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_irq", {15'd0, bus.irq}, 16'd0);
    chk("mid_rst_dout", bus.data_out, 16'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("post_rst_tick_c%0d", c), {15'd0, bus.tick}, {15'd0, (c == 9)});
      @(negedge clk);
    end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 16'h0000, $sformatf("post_rst_reg%0d", a));
    end
    chk("post_rst_irq", {15'd0, bus.irq}, 16'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 16'(sbq.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICKS_PER_SECOND, default 1000, channel decrement rate in Hz; prescaler terminal value PCOUNT = CLOCK_FREQUENCY/TICKS_PER_SECOND - 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  bus select for this block.
REQ-006 SHALL have port wr_en  input  1  write strobe; a write occurs only when en=1 and wr_en=1.
REQ-007 SHALL have port addr  input  4  register address; addr[3:2] = channel 0-3, addr[1:0] = register.
REQ-008 SHALL have port data_in  input  16  write data.
REQ-009 SHALL have port data_out  output  16  registered read data.
REQ-010 SHALL have port irq  output  1  level interrupt, OR over channels of (pending AND irq_en).
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each prescaler terminal count.

Function
REQ-012 SHALL keep a 24-bit prescaler counting 0..PCOUNT, wrapping to 0; tick=1 in the cycle the prescaler equals PCOUNT.
REQ-013 SHALL NOT restart the prescaler on any register write; all channels share one tick.
REQ-014 SHALL hold per channel: COUNT[15:0], RELOAD[15:0], CTRL {run bit0, auto bit1, irq_en bit2}, pending bit.
REQ-015 SHALL map addr[1:0]: 0=COUNT, 1=RELOAD, 2=CTRL (bits 15:3 read 0), 3=STATUS.
REQ-016 SHALL return STATUS read as bit0 = this channel's pending, bits 7:4 = pending of channels 3..0, other bits 0.
REQ-017 SHALL clear pending on a STATUS write with data_in[0]=1; data_in[0]=0 has no effect.
REQ-018 SHALL, on a tick, for each channel with run=1 and COUNT!=0: if COUNT>1, COUNT <= COUNT-1; if COUNT==1, set pending and load COUNT <= (auto ? RELOAD : 0).
REQ-019 SHALL leave COUNT unchanged on a tick when run=0 or COUNT==0 (no underflow, no wrap to 0xFFFF).
REQ-020 SHALL give a COUNT write priority over a same-cycle tick decrement for that channel; other channels decrement normally.
REQ-021 SHALL give pending-set priority over a same-cycle STATUS clear (pending remains 1).
REQ-022 SHALL, with auto=1 and RELOAD=0, expire once to COUNT=0 and then stop.
REQ-023 SHALL update data_out one cycle after en=1, wr_en=0, reflecting register state before that edge; data_out holds its value otherwise.
REQ-024 SHALL update irq combinationally from registered pending and irq_en (visible the cycle after pending sets).

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, clear prescaler, all COUNT, RELOAD, CTRL, pending, and data_out to 0; tick=0 and irq=0 the following cycle.
REQ-026 SHALL give reset priority over writes and ticks in the same cycle; a reset mid-countdown discards all channel state.

Verification (CLOCK_FREQUENCY=10, TICKS_PER_SECOND=1, PCOUNT=9)
REQ-027 SHALL verify: release reset, idle 30 cycles -> tick pulses at cycles 9, 19, 29; data_out=0, irq=0.
REQ-028 SHALL verify: ch0 COUNT=3, CTRL=0x5 -> COUNT reads 2,1,0 after successive ticks; pending=1 and irq=1 after third tick; STATUS write 0x1 -> irq=0.
REQ-029 SHALL verify: ch1 COUNT=2, RELOAD=4, CTRL=0x3 -> after 2 ticks pending=1, COUNT=4; after 4 more ticks pending remains set, COUNT=4 again; irq stays 0.
REQ-030 SHALL verify: COUNT write 0x0010 coincident with tick on a running channel -> COUNT reads 0x0010, not 0x000F; STATUS clear coincident with expiry -> pending stays 1.
REQ-031 SHALL verify: run=0 with COUNT=5 over 3 ticks -> COUNT stays 5; run=1, COUNT=0 -> stays 0, no pending.
REQ-032 SHALL verify: rst_n=0 mid-countdown with ch2 COUNT=7 and pending set -> all reads 0, irq=0, next tick 10 cycles after reset release.
